// File: rtl/serial_deserializer.sv
// serial_deserializer
//   Serial-in, parallel-out receiver. Bits are shifted into a working
//   register and counted. When a word completes it moves into a separate
//   output holding register, so the next word can be collected while the
//   previous one waits on the valid/ready handshake.
//
// Ports
//   clk       : sole clock, rising edge
//   reset     : synchronous reset, active low
//   serIn     : serial data bit
//   serValid  : serIn carries a bit this cycle
//   serReady  : receiver accepts a bit this cycle (registered state only)
//   msbFirst  : 1 = first bit lands in MSB, 0 = first bit lands in LSB
//   align     : drop the partial word and restart the bit count
//   dataOut   : assembled word
//   outValid  : dataOut holds an unconsumed word
//   outReady  : consumer accepts dataOut
module serial_deserializer #(
  parameter int BITS = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            serIn,
  input  logic            serValid,
  output logic            serReady,
  input  logic            msbFirst,
  input  logic            align,
  output logic [BITS-1:0] dataOut,
  output logic            outValid,
  input  logic            outReady
);

  localparam int CNT_W = (BITS > 1) ? $clog2(BITS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BITS - 1);

  logic [BITS-1:0]  shift_reg;
  logic [BITS-1:0]  shift_base;
  logic [BITS-1:0]  shift_next;
  logic [CNT_W-1:0] bit_cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             at_last;
  logic             accept;
  logic             complete;

  assign at_last  = (bit_cnt == LAST);
  // Stall only when the holding register is full and the next bit would
  // complete a word; nothing here looks at outReady, so a same-cycle
  // consume still costs one stall cycle.
  assign serReady = !(outValid && at_last);
  assign accept   = serValid && serReady;
  // align restarts the count, so a bit accepted with it is bit 0, never
  // the final bit of a word.
  assign complete = accept && at_last && !align;

  always_comb begin
    shift_base = align ? '0 : shift_reg;
    shift_next = shift_base;
    if (accept) begin
      if (msbFirst) shift_next = {shift_base[BITS-2:0], serIn};
      else          shift_next = {serIn, shift_base[BITS-1:1]};
    end
  end

  always_comb begin
    cnt_next = bit_cnt;
    if (align)       cnt_next = accept ? CNT_W'(1) : '0;
    else if (accept) cnt_next = at_last ? '0 : bit_cnt + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      shift_reg <= '0;
      bit_cnt   <= '0;
      dataOut   <= '0;
      outValid  <= 1'b0;
    end else begin
      shift_reg <= shift_next;
      bit_cnt   <= cnt_next;
      // A completing word wins over a consume in the same cycle.
      if (complete) begin
        dataOut  <= shift_next;
        outValid <= 1'b1;
      end else if (outValid && outReady) begin
        outValid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_serial_deserializer.sv
module tb_serial_deserializer;

  localparam int BITS = 8;

  logic            clk = 1'b0;
  logic            reset;
  logic            serIn;
  logic            serValid;
  logic            serReady;
  logic            msbFirst;
  logic            align;
  logic [BITS-1:0] dataOut;
  logic            outValid;
  logic            outReady;

  int tests_run = 0;
  int failed    = 0;

  // Reference model: bits of the word in progress, in arrival order.
  int              m_bits[$];
  logic            m_valid;
  logic [BITS-1:0] m_data;

  always #5 clk = ~clk;

  serial_deserializer #(.BITS(BITS)) dut (
    .clk      (clk),
    .reset    (reset),
    .serIn    (serIn),
    .serValid (serValid),
    .serReady (serReady),
    .msbFirst (msbFirst),
    .align    (align),
    .dataOut  (dataOut),
    .outValid (outValid),
    .outReady (outReady)
  );

  function automatic logic m_ready();
    return !(m_valid && (m_bits.size() == BITS - 1));
  endfunction

  // Arrival index i maps to bit position BITS-1-i (MSB first) or i (LSB first).
  function automatic logic [BITS-1:0] m_word(input logic msb);
    logic [BITS-1:0] w;
    w = '0;
    for (int i = 0; i < m_bits.size(); i++) begin
      if (msb) w[BITS-1-i] = m_bits[i][0];
      else     w[i]        = m_bits[i][0];
    end
    return w;
  endfunction

  // Advance one clock with the inputs already driven, updating the model.
  task automatic cycle();
    logic acc;
    logic cons;
    acc  = serValid && m_ready();
    cons = m_valid && outReady;
    @(posedge clk);
    if (!reset) begin
      m_bits.delete();
      m_valid = 1'b0;
      m_data  = '0;
    end else begin
      if (align) m_bits.delete();
      if (acc) m_bits.push_back(int'(serIn));
      if (m_bits.size() == BITS) begin
        m_data  = m_word(msbFirst);
        m_bits.delete();
        m_valid = 1'b1;
      end else if (cons) begin
        m_valid = 1'b0;
      end
    end
    #1;
  endtask

  task automatic drive_bit(input logic b);
    serValid = 1'b1;
    serIn    = b;
    cycle();
    serValid = 1'b0;
    align    = 1'b0;
  endtask

  // Index 0 is the first bit transmitted for the given order.
  function automatic logic tx_bit(input logic [BITS-1:0] w, input int i, input logic msb);
    return msb ? w[BITS-1-i] : w[i];
  endfunction

  task automatic test_reset();
    reset = 1'b0; serValid = 1'b1; serIn = 1'b1; align = 1'b0; outReady = 1'b0;
    cycle();
    cycle();
    reset = 1'b1; serValid = 1'b0;
    tests_run++;
    if ({outValid, serReady, dataOut} !== {1'b0, 1'b1, 8'h00}) begin
      failed++;
      $display("FAIL reset_state: got valid=%b ready=%b data=%h, want 0 1 00", outValid, serReady, dataOut);
    end
  endtask

  task automatic test_lsb_first();
    logic [BITS-1:0] seq;
    seq = 8'b10100101;
    msbFirst = 1'b0; outReady = 1'b1;
    for (int i = 0; i < BITS; i++) begin
      drive_bit(seq[BITS-1-i]);
      tests_run++;
      if (outValid !== (i == BITS - 1)) begin
        failed++;
        $display("FAIL lsb_valid_bit%0d: got %b, want %b", i, outValid, (i == BITS - 1));
      end
    end
    tests_run++;
    if (dataOut !== 8'hA5) begin
      failed++;
      $display("FAIL lsb_word: got %h, want a5", dataOut);
    end
    cycle();
    tests_run++;
    if (outValid !== 1'b0) begin
      failed++;
      $display("FAIL lsb_valid_one_cycle: got %b, want 0", outValid);
    end
  endtask

  task automatic test_msb_first();
    logic [BITS-1:0] seqs [2];
    logic [BITS-1:0] want [2];
    seqs[0] = 8'b10100101; want[0] = 8'hA5;
    seqs[1] = 8'b00010010; want[1] = 8'h12;
    msbFirst = 1'b1; outReady = 1'b1;
    for (int w = 0; w < 2; w++) begin
      for (int i = 0; i < BITS; i++) drive_bit(seqs[w][BITS-1-i]);
      tests_run++;
      if ({outValid, dataOut} !== {1'b1, want[w]}) begin
        failed++;
        $display("FAIL msb_word%0d: got valid=%b data=%h, want 1 %h", w, outValid, dataOut, want[w]);
      end
    end
    cycle();
  endtask

  task automatic test_backpressure();
    msbFirst = 1'b1; outReady = 1'b0;
    for (int i = 0; i < BITS; i++) drive_bit(tx_bit(8'h3C, i, 1'b1));
    for (int i = 0; i < BITS - 1; i++) begin
      drive_bit(tx_bit(8'hC3, i, 1'b1));
      tests_run++;
      if (serReady !== (i < BITS - 2)) begin
        failed++;
        $display("FAIL bp_ready_bit%0d: got %b, want %b", i, serReady, (i < BITS - 2));
      end
    end
    // Offer the last bit while stalled: it must not be taken.
    serValid = 1'b1; serIn = 1'b1;
    cycle();
    cycle();
    tests_run++;
    if ({outValid, serReady, dataOut} !== {1'b1, 1'b0, 8'h3C}) begin
      failed++;
      $display("FAIL bp_hold: got valid=%b ready=%b data=%h, want 1 0 3c", outValid, serReady, dataOut);
    end
    outReady = 1'b1;
    cycle();
    outReady = 1'b0;
    tests_run++;
    if ({outValid, serReady} !== 2'b01) begin
      failed++;
      $display("FAIL bp_consume: got valid=%b ready=%b, want 0 1", outValid, serReady);
    end
    cycle();
    serValid = 1'b0;
    tests_run++;
    if ({outValid, dataOut} !== {1'b1, 8'hC3}) begin
      failed++;
      $display("FAIL bp_last_word: got valid=%b data=%h, want 1 c3", outValid, dataOut);
    end
    outReady = 1'b1;
    cycle();
  endtask

  task automatic test_align();
    logic b;
    logic [BITS-1:0] w;
    msbFirst = 1'b1; outReady = 1'b1;
    for (int i = 0; i < 5; i++) drive_bit(1'($urandom_range(0, 1)));
    align = 1'b1;
    for (int i = 0; i < BITS; i++) begin
      drive_bit(tx_bit(8'h81, i, 1'b1));
      tests_run++;
      if (outValid !== (i == BITS - 1)) begin
        failed++;
        $display("FAIL align_valid_bit%0d: got %b, want %b", i, outValid, (i == BITS - 1));
      end
    end
    tests_run++;
    if (dataOut !== 8'h81) begin
      failed++;
      $display("FAIL align_word: got %h, want 81", dataOut);
    end
    // align together with the would-be final bit: no word, that bit starts a new one.
    msbFirst = 1'b0;
    w = 8'($urandom);
    for (int i = 0; i < BITS - 1; i++) drive_bit(1'($urandom_range(0, 1)));
    align = 1'b1;
    drive_bit(w[0]);
    tests_run++;
    if (outValid !== 1'b0) begin
      failed++;
      $display("FAIL align_final_bit: got valid=%b, want 0", outValid);
    end
    for (int i = 1; i < BITS; i++) begin
      b = w[i];
      drive_bit(b);
    end
    tests_run++;
    if ({outValid, dataOut} !== {1'b1, w}) begin
      failed++;
      $display("FAIL align_final_word: got valid=%b data=%h, want 1 %h", outValid, dataOut, w);
    end
    cycle();
  endtask

  task automatic test_reset_mid();
    logic [BITS-1:0] w;
    msbFirst = 1'b1; outReady = 1'b0;
    for (int i = 0; i < BITS; i++) drive_bit(1'($urandom_range(0, 1)));
    for (int i = 0; i < 4; i++) drive_bit(1'($urandom_range(0, 1)));
    reset = 1'b0; serValid = 1'b1; serIn = 1'b1; align = 1'b1; outReady = 1'b1;
    cycle();
    reset = 1'b1; serValid = 1'b0; align = 1'b0; outReady = 1'b1;
    tests_run++;
    if ({outValid, serReady, dataOut} !== {1'b0, 1'b1, 8'h00}) begin
      failed++;
      $display("FAIL reset_mid: got valid=%b ready=%b data=%h, want 0 1 00", outValid, serReady, dataOut);
    end
    w = 8'($urandom);
    for (int i = 0; i < BITS; i++) drive_bit(tx_bit(w, i, 1'b1));
    tests_run++;
    if ({outValid, dataOut} !== {1'b1, w}) begin
      failed++;
      $display("FAIL reset_mid_word: got valid=%b data=%h, want 1 %h", outValid, dataOut, w);
    end
    cycle();
  endtask

  task automatic test_back_to_back();
    logic [BITS-1:0] w [2];
    int n_ready_low;
    w[0] = 8'($urandom); w[1] = 8'($urandom);
    msbFirst = 1'b0; outReady = 1'b1; n_ready_low = 0;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < BITS; i++) begin
        if (!serReady) n_ready_low++;
        serValid = 1'b1; serIn = tx_bit(w[k], i, 1'b0);
        cycle();
        tests_run++;
        if (outValid !== (i == BITS - 1)) begin
          failed++;
          $display("FAIL b2b_valid_w%0d_bit%0d: got %b, want %b", k, i, outValid, (i == BITS - 1));
        end
      end
      tests_run++;
      if (dataOut !== w[k]) begin
        failed++;
        $display("FAIL b2b_word%0d: got %h, want %h", k, dataOut, w[k]);
      end
    end
    serValid = 1'b0;
    tests_run++;
    if (n_ready_low !== 0) begin
      failed++;
      $display("FAIL b2b_no_stall: got %0d stall cycles, want 0", n_ready_low);
    end
    cycle();
  endtask

  task automatic test_random();
    msbFirst = 1'($urandom_range(0, 1));
    for (int c = 0; c < 400; c++) begin
      serValid = 1'($urandom_range(0, 3) != 0);
      serIn    = 1'($urandom_range(0, 1));
      outReady = 1'($urandom_range(0, 2) == 0);
      align    = 1'($urandom_range(0, 19) == 0);
      cycle();
      tests_run++;
      if ({outValid, serReady} !== {m_valid, m_ready()}) begin
        failed++;
        $display("FAIL rand_flags_c%0d: got valid=%b ready=%b, want %b %b", c, outValid, serReady, m_valid, m_ready());
      end
      if (m_valid) begin
        tests_run++;
        if (dataOut !== m_data) begin
          failed++;
          $display("FAIL rand_data_c%0d: got %h, want %h", c, dataOut, m_data);
        end
      end
    end
    serValid = 1'b0; align = 1'b0; outReady = 1'b1;
    cycle();
  endtask

  initial begin
    reset = 1'b0; serIn = 1'b0; serValid = 1'b0; msbFirst = 1'b0;
    align = 1'b0; outReady = 1'b0;
    m_valid = 1'b0; m_data = '0;
    #2;
    test_reset();
    test_lsb_first();
    test_msb_first();
    test_backpressure();
    test_align();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule

// File: doc/serial_deserializer.md
# serial_deserializer

Serial-in, parallel-out receiver that rebuilds `BITS`-wide words from a one-bit stream, such as the stream produced by the universal shift register's shift-left and shift-right modes. It pairs a shift register and bit counter with a separate output holding register, so the next word can be collected while the previous one waits on a valid/ready handshake. It sits between a serial link and a word-oriented consumer.

## Interface
- `BITS`, default 8: word width; must be ≥ 2. The counter width is clog2(BITS).
- `clk`  input  1: sole clock; all state updates on the rising edge.
- `reset`  input  1: synchronous, active-low reset; sampled on the rising edge of `clk`.
- `serIn`  input  1: serial data bit.
- `serValid`  input  1: `serIn` carries a bit this cycle.
- `serReady`  output  1: receiver accepts a bit this cycle. A bit transfers when `serValid && serReady`.
- `msbFirst`  input  1: bit-order select. 1 = first bit lands in the MSB (shift left). 0 = first bit lands in the LSB (shift right).
- `align`  input  1: discard the partial word and restart the bit count.
- `dataOut`  output  BITS: assembled word.
- `outValid`  output  1: `dataOut` holds an unconsumed word.
- `outReady`  input  1: consumer accepts `dataOut`; the word transfers when `outValid && outReady`.

## Operation
- State:
  - `shiftReg[BITS-1:0]`
  - `bitCnt` (0..BITS-1)
  - `dataOut` register
  - `outValid` flag
- Bit accept, `msbFirst`=1: `shiftReg <= {shiftReg[BITS-2:0], serIn}`.
- Bit accept, `msbFirst`=0: `shiftReg <= {serIn, shiftReg[BITS-1:1]}`.
- `msbFirst` is sampled on every accepted bit. It must be held stable for a whole word. Changing it mid-word without `align` yields an undefined word value but no protocol error.
- Counting: each accepted bit increments `bitCnt`. On the accept where `bitCnt == BITS-1`:
  - the completed word (including the current bit) is written to `dataOut`;
  - `outValid` is set;
  - `bitCnt` wraps to 0.
- Output handshake:
  - `outValid` clears on `outValid && outReady` unless a new word completes in the same cycle; completion wins and `outValid` stays 1.
  - `dataOut` is stable while `outValid && !outReady`.
- Backpressure: `serReady = !(outValid && bitCnt == BITS-1)`.
  - It depends only on registered state; there is no combinational path from `outReady` or `serValid`.
  - As a result, a consumer accepting in the same cycle still costs one stall cycle.
- Align: when `align`=1, `bitCnt` is forced to 0 and `shiftReg` is cleared.
  - If `serValid && serReady` in the same cycle, that bit is accepted as bit 0 of the new word, so `bitCnt` becomes 1.
  - `align` does not affect `dataOut` or `outValid`.
- Bits presented while `serReady`=0 are not consumed. The sender must hold them.
- There is no overrun path: the serial side always stalls instead of overwriting `dataOut`.

## Timing
- Reset (`reset`=0 at a clock edge) applies the following on that edge, regardless of other inputs:
  - `shiftReg`=0, `bitCnt`=0, `dataOut`=0, `outValid`=0;
  - hence `serReady`=1 from the next cycle.
- Reset in the middle of a word discards the partial word and any pending `dataOut`.
- Latency: `dataOut`/`outValid` update at the clock edge that accepts the final bit, so they are visible in the following cycle.
- Throughput:
  - one word per `BITS` accepted bits when `outReady` is held at 1;
  - with `outReady` low, at most `BITS-1` further bits are accepted before `serReady` drops.
- Simultaneous events:
  - consume + complete in one cycle: the new word replaces the old and `outValid` stays 1;
  - `align` + final bit: `align` wins, no word completes, and `bitCnt` becomes 1.

## Test plan
- LSB-first: `msbFirst`=0, `outReady`=1, bits 1,0,1,0,0,1,0,1 on consecutive cycles → `dataOut`=0xA5 with `outValid`=1 for exactly one cycle, starting the cycle after the 8th bit.
- MSB-first: `msbFirst`=1, same bit sequence → `dataOut`=0xA5. Then sequence 0,0,0,1,0,0,1,0 → 0x12.
- Backpressure:
  - `outReady`=0; send 0x3C and then 7 bits of 0xC3 → `serReady`=0 with 0x3C held.
  - Pulse `outReady` for one cycle → 0x3C consumed and `serReady`=1 on the next cycle.
  - Send the last bit → `dataOut`=0xC3.
- Align: 5 random bits, then `align`=1 together with the first bit of 0x81, then the remaining 7 bits → `dataOut`=0x81 and no extra word.
- Reset mid-operation: 4 bits sent and a word pending; assert `reset`=0 for one cycle → `dataOut`=0, `outValid`=0, `serReady`=1. The next 8 bits produce the correct word.
- Back-to-back: 16 bits with `outReady`=1 and `serValid`=1 continuously → two words on consecutive 8-cycle boundaries, with no `serReady` deassertion.
